// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and the MEM stage.
// One transaction is in flight at a time. Data requests win ties because MEM
// holds the older instruction. A watchdog aborts a transaction that never
// gets m_ack, and halt blocks new fetch grants.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    input  logic              halt,
    output logic              m_valid,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata,
    output logic              stall_if,
    output logic              stall_mem,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_D = 2'd1;
    localparam logic [1:0] BUSY_I = 2'd2;

    logic [1:0]       state;
    logic [CNT_W-1:0] wd_cnt;
    logic             mem_take;
    logic             if_take;
    logic             done;

    // Request qualification: a requester still holds req during the cycle its
    // ready pulse is visible, so that request is already served and must not
    // be granted a second time. Stalls follow the outstanding requests.
    always_comb begin
        mem_take  = mem_req & ~mem_ready;
        if_take   = if_req & ~if_ready & ~halt;
        done      = m_ack | (wd_cnt == CNT_LAST);
        stall_mem = mem_req & ~mem_ready;
        stall_if  = stall_mem | (if_req & ~if_ready);
    end

    // Arbitration FSM, memory-side registers, watchdog and result return.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            wd_cnt    <= '0;
            m_valid   <= 1'b0;
            m_we      <= 1'b0;
            m_addr    <= '0;
            m_wdata   <= '0;
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if_rdata  <= '0;
            mem_rdata <= '0;
            bus_err   <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (mem_take) begin
                        state   <= BUSY_D;
                        m_valid <= 1'b1;
                        m_we    <= mem_we;
                        m_addr  <= mem_addr;
                        m_wdata <= mem_wdata;
                    end else if (if_take) begin
                        state   <= BUSY_I;
                        m_valid <= 1'b1;
                        m_we    <= 1'b0;
                        m_addr  <= if_addr;
                    end
                end
                BUSY_D, BUSY_I: begin
                    if (done) begin
                        // m_ack wins over a watchdog expiry in the same cycle;
                        // an aborted transaction returns zero (a nop for fetch).
                        state   <= IDLE;
                        wd_cnt  <= '0;
                        m_valid <= 1'b0;
                        m_we    <= 1'b0;
                        if (!m_ack) begin
                            bus_err <= 1'b1;
                        end
                        if (state == BUSY_D) begin
                            mem_ready <= 1'b1;
                            mem_rdata <= m_ack ? m_rdata : '0;
                        end else begin
                            if_ready  <= 1'b1;
                            if_rdata  <= m_ack ? m_rdata : '0;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    m_valid <= 1'b0;
                    m_we    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios plus randomized request
// mixes, checked against a transaction-level model of the memory and arbiter.
module tb_mem_port_arbiter;

    localparam int TO = 16;

    logic        clk;
    logic        reset_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_ready;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        halt;
    logic        m_valid;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        stall_if;
    logic        stall_mem;
    logic        bus_err;

    int n_run  = 0;
    int n_fail = 0;

    // model_mem is indexed by the requester's address, phys_mem by the
    // address the arbiter actually puts on the memory bus.
    logic [31:0] model_mem [8];
    logic [31:0] phys_mem  [8];
    logic        exp_bus_err;

    mem_port_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_ready (if_ready),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready),
        .halt     (halt),
        .m_valid  (m_valid),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata),
        .stall_if (stall_if),
        .stall_mem(stall_mem),
        .bus_err  (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Presents one fetch and/or one data request, acts as the memory (ack d
    // cycles after the grant is seen, d >= TO meaning never) and checks every
    // cycle against the model: data before fetch, halt blocks fetch, ready one
    // cycle after ack or TO cycles after grant on timeout.
    task automatic run_case(input string tag,
                            input logic want_if, input logic [31:0] ia,
                            input logic want_mem, input logic we,
                            input logic [31:0] ma, input logic [31:0] wd,
                            input int d_if, input int d_mem, input logic hlt);
        logic        kq[$];
        int          dq[$];
        int          nexp, served, cyc, g, ack_at, rdy_at, d;
        logic        active, kind, drop_if, drop_mem, tmo, exp_ir, exp_mr;
        logic [31:0] exp_addr, exp_rd;
        if (want_mem) begin kq.push_back(1'b1); dq.push_back(d_mem); end
        if (want_if && !hlt) begin kq.push_back(1'b0); dq.push_back(d_if); end
        nexp = kq.size(); served = 0; cyc = 0; g = 0; d = 0;
        ack_at = -1; rdy_at = -1;
        active = 1'b0; kind = 1'b0; tmo = 1'b0; drop_if = 1'b0; drop_mem = 1'b0;
        exp_addr = '0; exp_rd = '0;
        if_req = want_if; if_addr = ia;
        mem_req = want_mem; mem_we = we; mem_addr = ma; mem_wdata = wd;
        halt = hlt;
        while (served < nexp && cyc < 200) begin
            @(posedge clk); #1; cyc++;
            m_ack = 1'b0; m_rdata = $urandom;
            if (drop_mem) begin mem_req = 1'b0; drop_mem = 1'b0; end
            if (drop_if)  begin if_req  = 1'b0; drop_if  = 1'b0; end
            exp_mr = active && kind && (cyc == rdy_at);
            exp_ir = active && !kind && (cyc == rdy_at);
            chk1({tag, ".mem_ready"}, mem_ready, exp_mr);
            chk1({tag, ".if_ready"}, if_ready, exp_ir);
            if (active && cyc == rdy_at) begin
                if (kind) chk({tag, ".mem_rdata"}, mem_rdata, exp_rd);
                else      chk({tag, ".if_rdata"}, if_rdata, exp_rd);
                exp_bus_err = exp_bus_err | tmo;
                chk1({tag, ".bus_err"}, bus_err, exp_bus_err);
                served++;
                active = 1'b0;
                if (kind) drop_mem = 1'b1; else drop_if = 1'b1;
            end else if (m_valid && !active) begin
                chk1({tag, ".grant_expected"}, logic'(kq.size() != 0), 1'b1);
                if (kq.size() != 0) begin
                    active   = 1'b1;
                    g        = cyc;
                    kind     = kq.pop_front();
                    d        = dq.pop_front();
                    tmo      = (d >= TO);
                    exp_addr = kind ? ma : ia;
                    chk({tag, ".m_addr"}, m_addr, exp_addr);
                    chk1({tag, ".m_we"}, m_we, kind & we);
                    if (kind && we) chk({tag, ".m_wdata"}, m_wdata, wd);
                    rdy_at = tmo ? g + TO : g + d + 1;
                    ack_at = tmo ? -1 : g + d;
                    exp_rd = tmo ? 32'h0 : model_mem[exp_addr[4:2]];
                    if (kind && we && !tmo) model_mem[exp_addr[4:2]] = wd;
                end
            end
            chk1({tag, ".m_valid"}, m_valid, active);
            if (active && cyc == ack_at) begin
                m_ack   = 1'b1;
                m_rdata = phys_mem[m_addr[4:2]];
                if (m_we) phys_mem[m_addr[4:2]] = m_wdata;
            end
            #1;
            chk1({tag, ".stall_mem"}, stall_mem, mem_req & ~exp_mr);
            chk1({tag, ".stall_if"}, stall_if, (mem_req & ~exp_mr) | (if_req & ~exp_ir));
        end
        chk({tag, ".served"}, 32'(served), 32'(nexp));
        for (int t = 0; t < 3; t++) begin
            @(posedge clk); #1;
            m_ack = 1'b0;
            if (drop_mem) begin mem_req = 1'b0; drop_mem = 1'b0; end
            if (drop_if)  begin if_req  = 1'b0; drop_if  = 1'b0; end
            chk1({tag, ".idle_m_valid"}, m_valid, 1'b0);
            chk1({tag, ".idle_ready"}, if_ready | mem_ready, 1'b0);
        end
        if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; halt = 1'b0;
    endtask

    initial begin
        logic        wi, wm, wwe, wh;
        logic [31:0] ra, rm, rd;
        reset_n = 1'b0; if_req = 1'b0; if_addr = '0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = '0; mem_wdata = '0; halt = 1'b0; m_ack = 1'b0; m_rdata = '0;
        exp_bus_err = 1'b0;
        for (int i = 0; i < 8; i++) begin
            model_mem[i] = $urandom;
            phys_mem[i]  = model_mem[i];
        end

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk1("rst.m_valid", m_valid, 1'b0);
        chk1("rst.m_we", m_we, 1'b0);
        chk("rst.m_addr", m_addr, 32'h0);
        chk("rst.m_wdata", m_wdata, 32'h0);
        chk1("rst.if_ready", if_ready, 1'b0);
        chk1("rst.mem_ready", mem_ready, 1'b0);
        chk("rst.if_rdata", if_rdata, 32'h0);
        chk("rst.mem_rdata", mem_rdata, 32'h0);
        chk1("rst.bus_err", bus_err, 1'b0);
        chk1("rst.stall_if", stall_if, 1'b0);
        reset_n = 1'b1;

        // Fetch only, ack two cycles after m_valid
        model_mem[0] = 32'h8C41_0004;
        phys_mem[0]  = 32'h8C41_0004;
        run_case("fetch", 1'b1, 32'h100, 1'b0, 1'b0, 32'h0, 32'h0, 2, 0, 1'b0);

        // Same-cycle conflict: load first, then fetch
        run_case("conflict", 1'b1, 32'h104, 1'b1, 1'b0, 32'h2000, 32'h0, 1, 1, 1'b0);

        // Store with immediate ack
        run_case("store", 1'b0, 32'h0, 1'b1, 1'b1, 32'h2004, 32'hDEAD_BEEF, 0, 0, 1'b0);

        // Randomized request mixes
        for (int i = 0; i < 24; i++) begin
            wm  = 1'($urandom);
            wi  = wm ? 1'($urandom) : 1'b1;
            wwe = 1'($urandom);
            wh  = ($urandom_range(3) == 0);
            ra  = 32'h100 + 32'(4 * $urandom_range(7));
            rm  = 32'h2000 + 32'(4 * $urandom_range(7));
            rd  = $urandom;
            run_case("rand", wi, ra, wm, wwe, rm, rd,
                     int'($urandom_range(4)), int'($urandom_range(4)), wh);
        end

        // Watchdog timeout on a fetch, then a late ack that must be ignored
        run_case("timeout", 1'b1, 32'h10C, 1'b0, 1'b0, 32'h0, 32'h0, TO + 5, 0, 1'b0);
        @(posedge clk); #1;
        m_ack = 1'b1; m_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        m_ack = 1'b0;
        chk1("late_ack.m_valid", m_valid, 1'b0);
        chk1("late_ack.if_ready", if_ready, 1'b0);
        chk1("late_ack.mem_ready", mem_ready, 1'b0);
        chk1("late_ack.bus_err", bus_err, 1'b1);

        // halt blocks fetch; a data request is still served
        run_case("halt_if", 1'b1, 32'h110, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 1'b1);
        run_case("halt_mem", 1'b1, 32'h110, 1'b1, 1'b0, 32'h2008, 32'h0, 1, 1, 1'b1);

        // Asynchronous reset in the middle of a data transaction
        @(posedge clk); #1;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h200C;
        @(posedge clk); #1;
        chk1("arst.granted", m_valid, 1'b1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        #1;
        chk1("arst.m_valid", m_valid, 1'b0);
        chk("arst.m_addr", m_addr, 32'h0);
        chk1("arst.mem_ready", mem_ready, 1'b0);
        chk1("arst.bus_err", bus_err, 1'b0);
        mem_req = 1'b0;
        exp_bus_err = 1'b0;
        @(posedge clk); #1;
        chk1("arst.hold_ready", mem_ready, 1'b0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk1("arst.no_pulse", mem_ready | if_ready, 1'b0);
        chk1("arst.idle", m_valid, 1'b0);
        run_case("post_reset", 1'b1, 32'h114, 1'b0, 1'b0, 32'h0, 32'h0, 1, 0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
